// File: rtl/stream_seq_checker_if.sv
// Stream sequence checker bus: received words plus the checker's status and statistics.
interface stream_seq_checker_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
);
   logic             en;
   logic [WIDTH-1:0] data;
   logic             clear;
   logic             locked;
   logic [WIDTH-1:0] expected;
   logic             failure;
   logic [CNT_W-1:0] ok_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             first_err_valid;
   logic [WIDTH-1:0] first_err_data;
   logic [WIDTH-1:0] first_err_exp;

   modport master (
      output en, data, clear,
      input  locked, expected, failure, ok_cnt, err_cnt,
             first_err_valid, first_err_data, first_err_exp
   );

   modport slave (
      input  en, data, clear,
      output locked, expected, failure, ok_cnt, err_cnt,
             first_err_valid, first_err_data, first_err_exp
   );
endinterface

// File: rtl/stream_seq_checker.sv
// Incrementing-sequence checker: hunts for a counting stream, locks, then counts matches/errors.
// Optional macro STREAM_SEQ_CHECKER_AUTO_RESYNC_EN: drop back to HUNT after RESYNC_ERRS consecutive errors.
module stream_seq_checker #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned LOCK_COUNT  = 2,
   parameter int unsigned RESYNC_ERRS = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   stream_seq_checker_if.slave bus
);

   localparam int unsigned RUN_W = 4;

   typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} state_t;

   if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
      $error("LOCK_COUNT must be in 1..15");
   end
   if (RESYNC_ERRS < 1 || RESYNC_ERRS > 15) begin : g_bad_resync
      $error("RESYNC_ERRS must be in 1..15");
   end

   state_t           state;
   logic [RUN_W-1:0] run;
   logic             match_c;
`ifdef STREAM_SEQ_CHECKER_AUTO_RESYNC_EN
   logic [RUN_W-1:0] cerr;
`endif

   assign match_c = (bus.data == bus.expected);

   // Sequencer FSM, statistics and first-error capture; clear is applied last so it wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= HUNT;
         run                 <= '0;
         bus.locked          <= 1'b0;
         bus.expected        <= '0;
         bus.failure         <= 1'b0;
         bus.ok_cnt          <= '0;
         bus.err_cnt         <= '0;
         bus.first_err_valid <= 1'b0;
         bus.first_err_data  <= '0;
         bus.first_err_exp   <= '0;
`ifdef STREAM_SEQ_CHECKER_AUTO_RESYNC_EN
         cerr                <= '0;
`endif
      end else begin
         bus.failure <= 1'b0;
         if (bus.en) begin
            unique case (state)
               HUNT: begin
                  bus.expected <= bus.data + WIDTH'(1);
                  run          <= RUN_W'(1);
                  state        <= (LOCK_COUNT == 1) ? LOCKED : LOCKING;
                  bus.locked   <= (LOCK_COUNT == 1);
               end
               LOCKING: begin
                  bus.expected <= bus.data + WIDTH'(1);
                  if (match_c) begin
                     run <= run + RUN_W'(1);
                     if (32'(run) + 32'd1 >= LOCK_COUNT) begin
                        state      <= LOCKED;
                        bus.locked <= 1'b1;
                     end
                  end else begin
                     run <= RUN_W'(1);
                  end
               end
               LOCKED: begin
                  // Free-running reference: never realign to the received word.
                  bus.expected <= bus.expected + WIDTH'(1);
                  if (match_c) begin
                     if (bus.ok_cnt != '1) bus.ok_cnt <= bus.ok_cnt + CNT_W'(1);
`ifdef STREAM_SEQ_CHECKER_AUTO_RESYNC_EN
                     cerr <= '0;
`endif
                  end else begin
                     bus.failure <= 1'b1;
                     if (bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + CNT_W'(1);
                     if (!bus.first_err_valid) begin
                        bus.first_err_valid <= 1'b1;
                        bus.first_err_data  <= bus.data;
                        bus.first_err_exp   <= bus.expected;
                     end
`ifdef STREAM_SEQ_CHECKER_AUTO_RESYNC_EN
                     if (32'(cerr) + 32'd1 >= RESYNC_ERRS) begin
                        state      <= HUNT;
                        bus.locked <= 1'b0;
                        run        <= '0;
                        cerr       <= '0;
                     end else begin
                        cerr <= cerr + RUN_W'(1);
                     end
`endif
                  end
               end
               default: begin
                  state      <= HUNT;
                  bus.locked <= 1'b0;
               end
            endcase
         end
         if (bus.clear) begin
            bus.ok_cnt          <= '0;
            bus.err_cnt         <= '0;
            bus.first_err_valid <= 1'b0;
            bus.first_err_data  <= '0;
            bus.first_err_exp   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed vector bench for stream_seq_checker (default build and saturating CNT_W=2 copy).
module tb_stream_seq_checker;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic [3:0] data;
      logic       clear;
      logic       locked;
      logic [3:0] expected;
      logic       failure;
      logic [7:0] ok;
      logic [7:0] err;
      logic       fev;
      logic [3:0] fed;
      logic [3:0] fee;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   stream_seq_checker_if #(.WIDTH(4), .CNT_W(8)) ia ();
   stream_seq_checker_if #(.WIDTH(4), .CNT_W(2)) ib ();

   stream_seq_checker #(.WIDTH(4), .CNT_W(8), .LOCK_COUNT(2), .RESYNC_ERRS(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(ia)
   );
   stream_seq_checker #(.WIDTH(4), .CNT_W(2), .LOCK_COUNT(2), .RESYNC_ERRS(3)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(ib)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [3:0] d, input logic c);
      rst_n = r;
      ia.en = e; ia.data = d; ia.clear = c;
      ib.en = e; ib.data = d; ib.clear = c;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mkv(input logic r, input logic e, input int d, input logic c,
                                input logic l, input int x, input logic f, input int ok,
                                input int err, input logic fev, input int fed, input int fee);
      vec_t t;
      t.rst_n = r; t.en = e; t.data = 4'(d); t.clear = c;
      t.locked = l; t.expected = 4'(x); t.failure = f;
      t.ok = 8'(ok); t.err = 8'(err); t.fev = fev; t.fed = 4'(fed); t.fee = 4'(fee);
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      rst_n = 1'b0;
      ia.en = 1'b0; ia.data = '0; ia.clear = 1'b0;
      ib.en = 1'b0; ib.data = '0; ib.clear = 1'b0;

      // reset, then counting stream 3..18 (mod 16): lock after 2nd word, 14 matches
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 16; i++)
         tbl.push_back(mkv(1, 1, (3 + i) % 16, 0, i >= 1, (4 + i) % 16, 0,
                           (i >= 2) ? i - 1 : 0, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 0, 7, 0, 1, 3, 0, 14, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mkv(1, 1, 3 + i, 0, 1, 4 + i, 0, 15 + i, 0, 0, 0, 0));
      // expected=7: send 9 twice, then a match
      tbl.push_back(mkv(1, 1, 9, 0, 1, 8, 1, 18, 1, 1, 9, 7));
      tbl.push_back(mkv(1, 1, 9, 0, 1, 9, 1, 18, 2, 1, 9, 7));
      tbl.push_back(mkv(1, 1, 9, 0, 1, 10, 0, 19, 2, 1, 9, 7));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mkv(1, 1, 10 + i, 0, 1, 11 + i, 0, 20 + i, 2, 1, 9, 7));
      // wrap 14,15,0,1
      tbl.push_back(mkv(1, 1, 14, 0, 1, 15, 0, 24, 2, 1, 9, 7));
      tbl.push_back(mkv(1, 1, 15, 0, 1, 0, 0, 25, 2, 1, 9, 7));
      tbl.push_back(mkv(1, 1, 0, 0, 1, 1, 0, 26, 2, 1, 9, 7));
      tbl.push_back(mkv(1, 1, 1, 0, 1, 2, 0, 27, 2, 1, 9, 7));
      tbl.push_back(mkv(1, 0, 5, 0, 1, 2, 0, 27, 2, 1, 9, 7));
      // clear with a same-cycle mismatch
      tbl.push_back(mkv(1, 1, 5, 1, 1, 3, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 1, 3, 0, 1, 4, 0, 1, 0, 0, 0, 0));

      @(negedge clk);
      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].en, tbl[i].data, tbl[i].clear);
         chk($sformatf("v%0d.locked", i),   int'(ia.locked),          int'(tbl[i].locked));
         chk($sformatf("v%0d.expected", i), int'(ia.expected),        int'(tbl[i].expected));
         chk($sformatf("v%0d.failure", i),  int'(ia.failure),         int'(tbl[i].failure));
         chk($sformatf("v%0d.ok_cnt", i),   int'(ia.ok_cnt),          int'(tbl[i].ok));
         chk($sformatf("v%0d.err_cnt", i),  int'(ia.err_cnt),         int'(tbl[i].err));
         chk($sformatf("v%0d.fev", i),      int'(ia.first_err_valid), int'(tbl[i].fev));
         chk($sformatf("v%0d.fed", i),      int'(ia.first_err_data),  int'(tbl[i].fed));
         chk($sformatf("v%0d.fee", i),      int'(ia.first_err_exp),   int'(tbl[i].fee));
      end

      // Consecutive mismatches while locked (expected 4,5,6 vs data 0)
      for (int k = 1; k <= 3; k++) begin
         drive(1, 1, 4'd0, 0);
         chk($sformatf("mm%0d.failure", k), int'(ia.failure), 1);
         chk($sformatf("mm%0d.err_cnt", k), int'(ia.err_cnt), k);
         chk($sformatf("mm%0d.sat_err", k), int'(ib.err_cnt), k);
         chk($sformatf("mm%0d.expected", k), int'(ia.expected), 4 + k);
      end
      chk("mm.fed", int'(ia.first_err_data), 0);
      chk("mm.fee", int'(ia.first_err_exp), 4);
`ifdef STREAM_SEQ_CHECKER_AUTO_RESYNC_EN
      chk("resync.locked", int'(ia.locked), 0);
      chk("resync.sat_locked", int'(ib.locked), 0);
      drive(1, 1, 4'd6, 0);
      chk("relock1.locked", int'(ia.locked), 0);
      drive(1, 1, 4'd7, 0);
      chk("relock2.locked", int'(ia.locked), 1);
      chk("relock2.expected", int'(ia.expected), 8);
      chk("relock2.err_cnt", int'(ia.err_cnt), 3);
      chk("relock2.fev", int'(ia.first_err_valid), 1);
`else
      chk("mm3.locked", int'(ia.locked), 1);
      for (int k = 4; k <= 5; k++) begin
         drive(1, 1, 4'd0, 0);
         chk($sformatf("mm%0d.err_cnt", k), int'(ia.err_cnt), k);
         chk($sformatf("mm%0d.sat_err", k), int'(ib.err_cnt), 3);
         chk($sformatf("mm%0d.locked", k), int'(ia.locked), 1);
         chk($sformatf("mm%0d.sat_locked", k), int'(ib.locked), 1);
      end
`endif

      // Reset for one cycle while locked with en=1 and clear=1
      drive(0, 1, 4'd4, 1);
      chk("rst.locked",   int'(ia.locked), 0);
      chk("rst.expected", int'(ia.expected), 0);
      chk("rst.failure",  int'(ia.failure), 0);
      chk("rst.ok_cnt",   int'(ia.ok_cnt), 0);
      chk("rst.err_cnt",  int'(ia.err_cnt), 0);
      chk("rst.fev",      int'(ia.first_err_valid), 0);
      chk("rst.fed",      int'(ia.first_err_data), 0);
      chk("rst.fee",      int'(ia.first_err_exp), 0);
      drive(1, 1, 4'd10, 0);
      chk("hunt.locked",   int'(ia.locked), 0);
      chk("hunt.expected", int'(ia.expected), 11);
      // Mismatch while LOCKING realigns silently
      drive(1, 1, 4'd5, 0);
      chk("lkmm.locked",   int'(ia.locked), 0);
      chk("lkmm.expected", int'(ia.expected), 6);
      chk("lkmm.failure",  int'(ia.failure), 0);
      chk("lkmm.err_cnt",  int'(ia.err_cnt), 0);
      drive(1, 1, 4'd6, 0);
      chk("lock.locked",   int'(ia.locked), 1);
      chk("lock.ok_cnt",   int'(ia.ok_cnt), 0);
      drive(1, 1, 4'd8, 0);
      chk("post.failure",  int'(ia.failure), 1);
      chk("post.err_cnt",  int'(ia.err_cnt), 1);
      chk("post.fee",      int'(ia.first_err_exp), 7);
      drive(1, 0, 4'd0, 0);
      chk("idle.failure",  int'(ia.failure), 0);
      chk("idle.expected", int'(ia.expected), 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
